pipearch_dot_batch: RTL and testbench

- Parametrised successor of the single-result dot operator.
- Computes BATCH dot products of LINES 512-bit-class lines each, emitting one 32-bit result per dot to the common-write path.
- Lane count, FIFO depth and left-buffer depth are parametrised.
- Adds a broadcast mode: the left vector (model) is read once, held in a local buffer and replayed against every right vector (sample), for GLM inference.

---
 rtl/pipearch_dot_pkg.sv | 28 ++
 rtl/pipearch_dot_lane_reduce.sv | 53 +++++
 rtl/pipearch_dot_batch.sv | 237 +++++++++++++++++++++++
 tb/tb_pipearch_dot_batch.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipearch_dot_pkg.sv
// Shared types, register field layout and lane arithmetic for the batched dot operator.
package pipearch_dot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } t_dotbatch_state;

  localparam int REGS0_BATCH_LSB  = 0;
  localparam int REGS0_BATCH_W    = 16;
  localparam int REGS0_LINES_LSB  = 16;
  localparam int REGS0_LINES_W    = 16;
  localparam int BCAST_BIT        = 0;
  localparam int ALMOSTFULL_SLACK = 8;

  // Signed 32x32 product, arithmetic shift by the fixed-point fraction, keep the low word.
  function automatic logic [31:0] mul_shift(input logic [31:0] a, input logic [31:0] b,
                                            input int frac);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    p = p >>> frac;
    return p[31:0];
  endfunction

endpackage

// File: rtl/pipearch_dot_lane_reduce.sv
// Per-lane multiply/shift followed by a registered adder tree, one tree level per cycle.
// Tags (valid/first/last) travel alongside so the sum leaves with its line's markers.
module pipearch_dot_lane_reduce
  import pipearch_dot_pkg::*;
#(
  parameter int LOG2_VALUES_PER_LINE = 4,
  parameter int FRAC_BITS            = 0
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  valid_i,
  input  logic                                  first_i,
  input  logic                                  last_i,
  input  logic [(32<<LOG2_VALUES_PER_LINE)-1:0] a_i,
  input  logic [(32<<LOG2_VALUES_PER_LINE)-1:0] b_i,
  output logic                                  valid_o,
  output logic                                  first_o,
  output logic                                  last_o,
  output logic [31:0]                           sum_o
);

  localparam int L = LOG2_VALUES_PER_LINE;
  localparam int N = 1 << L;

  // Heap-ordered tree: leaves at N-1..2N-2 hold products, node 0 is the root.
  // Each node registers the sum of its children, so depth == pipeline stage.
  logic [31:0] node_q [2*N-1];
  logic [L:0]  vld_q, first_q, last_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N - 1; i++) node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
    for (int i = 0; i < N; i++)
      node_q[N-1+i] <= mul_shift(a_i[32*i +: 32], b_i[32*i +: 32], FRAC_BITS);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      vld_q   <= {vld_q[L-1:0], valid_i};
      first_q <= {first_q[L-1:0], first_i};
      last_q  <= {last_q[L-1:0], last_i};
    end
  end

  assign valid_o = vld_q[L];
  assign first_o = first_q[L];
  assign last_o  = last_q[L];
  assign sum_o   = node_q[0];

endmodule

// File: rtl/pipearch_dot_batch.sv
// Batched dot-product engine with optional broadcast (model replay) of the left vector.
// Build option PIPEARCH_DOT_SATURATE_EN: saturating, per-dot sticky accumulation.
//
//   state | meaning
//   IDLE  | waiting for op_start, latches LINES/BATCH/mode
//   LOAD  | unused encoding, returns to IDLE
//   RUN   | consuming line pairs
//   DRAIN | last pair issued, waiting for final result write
//   DONE  | pulses op_done (and op_error) for one cycle
module pipearch_dot_batch
  import pipearch_dot_pkg::*;
#(
  parameter int LOG2_VALUES_PER_LINE = 4,
  parameter int LOG2_FIFO_DEPTH      = 6,
  parameter int LOG2_MAX_LINES       = 9,
  parameter int FRAC_BITS            = 0
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  op_start,
  output logic                                  op_done,
  output logic                                  op_error,
  input  logic [31:0]                           regs0,
  input  logic [31:0]                           regs1,
  input  logic                                  left_rvalid,
  input  logic [(32<<LOG2_VALUES_PER_LINE)-1:0] left_rdata,
  output logic                                  left_almostfull,
  input  logic                                  right_rvalid,
  input  logic [(32<<LOG2_VALUES_PER_LINE)-1:0] right_rdata,
  output logic                                  right_almostfull,
  output logic                                  result_we,
  output logic [31:0]                           result_wdata,
  input  logic                                  result_almostfull
);

  localparam int LINE_W = 32 << LOG2_VALUES_PER_LINE;
  localparam int AW     = LOG2_FIFO_DEPTH;
  localparam int FD     = 1 << AW;
  localparam int BUF_D  = 1 << LOG2_MAX_LINES;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   fcnt_t;

  localparam fcnt_t       FIFO_FULL = fcnt_t'(FD);
  localparam fcnt_t       AF_LVL    = fcnt_t'(FD - ALMOSTFULL_SLACK);
  localparam logic [16:0] BUF_LINES = 17'(BUF_D);

  logic [LINE_W-1:0] lf_mem [FD];
  logic [LINE_W-1:0] rf_mem [FD];
  logic [LINE_W-1:0] lbuf_q [BUF_D];
  ptr_t              lf_wp_q, lf_rp_q, rf_wp_q, rf_rp_q;
  fcnt_t             lf_cnt_q, rf_cnt_q;
  logic              lf_push, lf_pop, rf_push, rf_pop;

  t_dotbatch_state state_q;
  logic [15:0]     lines_q, batch_q, line_idx_q, dot_idx_q, res_cnt_q;
  logic            bcast_q, err_q, op_done_q, op_error_q;
  logic            replay, left_avail, fire, last_line, last_dot;
  logic [15:0]     start_lines, start_batch;
  logic [LINE_W-1:0] left_line;

  logic        red_vld, red_first, red_last;
  logic [31:0] red_sum, acc_q, acc_d, acc_base;
  logic        acc_last_q, result_we_q;
  logic [31:0] result_wdata_q;
  logic        unused_regs1;

  assign unused_regs1 = ^regs1[31:1];

  // Input FIFOs: writes while full are dropped.
  assign lf_push = left_rvalid && (lf_cnt_q != FIFO_FULL);
  assign rf_push = right_rvalid && (rf_cnt_q != FIFO_FULL);

  always_ff @(posedge clk) begin
    if (lf_push) lf_mem[lf_wp_q] <= left_rdata;
    if (rf_push) rf_mem[rf_wp_q] <= right_rdata;
    if (fire && bcast_q && !replay) lbuf_q[line_idx_q[LOG2_MAX_LINES-1:0]] <= lf_mem[lf_rp_q];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lf_wp_q  <= '0;
      lf_rp_q  <= '0;
      lf_cnt_q <= '0;
      rf_wp_q  <= '0;
      rf_rp_q  <= '0;
      rf_cnt_q <= '0;
    end else begin
      if (lf_push) lf_wp_q <= lf_wp_q + ptr_t'(1);
      if (lf_pop)  lf_rp_q <= lf_rp_q + ptr_t'(1);
      if (rf_push) rf_wp_q <= rf_wp_q + ptr_t'(1);
      if (rf_pop)  rf_rp_q <= rf_rp_q + ptr_t'(1);
      lf_cnt_q <= lf_cnt_q + fcnt_t'(lf_push) - fcnt_t'(lf_pop);
      rf_cnt_q <= rf_cnt_q + fcnt_t'(rf_push) - fcnt_t'(rf_pop);
    end
  end

  assign left_almostfull  = lf_cnt_q >= AF_LVL;
  assign right_almostfull = rf_cnt_q >= AF_LVL;

  // Broadcast dots after the first replay the buffered model instead of the FIFO.
  assign replay     = bcast_q && (dot_idx_q != 16'd0);
  assign left_avail = replay || (lf_cnt_q != '0);
  assign fire       = (state_q == ST_RUN) && left_avail && (rf_cnt_q != '0) && !result_almostfull;
  assign lf_pop     = fire && !replay;
  assign rf_pop     = fire;
  assign left_line  = replay ? lbuf_q[line_idx_q[LOG2_MAX_LINES-1:0]] : lf_mem[lf_rp_q];
  assign last_line  = line_idx_q == lines_q - 16'd1;
  assign last_dot   = dot_idx_q == batch_q - 16'd1;

  assign start_lines = regs0[REGS0_LINES_LSB +: REGS0_LINES_W];
  assign start_batch = regs0[REGS0_BATCH_LSB +: REGS0_BATCH_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      lines_q    <= '0;
      batch_q    <= '0;
      bcast_q    <= 1'b0;
      err_q      <= 1'b0;
      line_idx_q <= '0;
      dot_idx_q  <= '0;
      res_cnt_q  <= '0;
      op_done_q  <= 1'b0;
      op_error_q <= 1'b0;
    end else begin
      op_done_q  <= 1'b0;
      op_error_q <= 1'b0;
      if (acc_last_q) res_cnt_q <= res_cnt_q + 16'd1;
      case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            lines_q    <= start_lines;
            batch_q    <= start_batch;
            bcast_q    <= regs1[BCAST_BIT];
            line_idx_q <= '0;
            dot_idx_q  <= '0;
            res_cnt_q  <= '0;
            err_q      <= 1'b0;
            if (start_lines == 16'd0 || start_batch == 16'd0) begin
              state_q <= ST_DONE;
            end else if (regs1[BCAST_BIT] && ({1'b0, start_lines} > BUF_LINES)) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_LOAD: state_q <= ST_IDLE;
        ST_RUN: begin
          if (fire) begin
            if (last_line) begin
              line_idx_q <= '0;
              dot_idx_q  <= dot_idx_q + 16'd1;
              if (last_dot) state_q <= ST_DRAIN;
            end else begin
              line_idx_q <= line_idx_q + 16'd1;
            end
          end
        end
        ST_DRAIN: if (res_cnt_q == batch_q) state_q <= ST_DONE;
        ST_DONE: begin
          op_done_q  <= 1'b1;
          op_error_q <= err_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pipearch_dot_lane_reduce #(
    .LOG2_VALUES_PER_LINE(LOG2_VALUES_PER_LINE),
    .FRAC_BITS           (FRAC_BITS)
  ) u_reduce (
    .clk    (clk),
    .resetn (resetn),
    .valid_i(fire),
    .first_i(line_idx_q == 16'd0),
    .last_i (last_line),
    .a_i    (left_line),
    .b_i    (rf_mem[rf_rp_q]),
    .valid_o(red_vld),
    .first_o(red_first),
    .last_o (red_last),
    .sum_o  (red_sum)
  );

  // The first-line tag restarts the accumulator at each dot boundary.
  assign acc_base = red_first ? 32'd0 : acc_q;

`ifdef PIPEARCH_DOT_SATURATE_EN
  logic        sat_q, sat_d;
  logic [31:0] acc_sum;

  always_comb begin
    acc_sum = acc_base + red_sum;
    acc_d   = acc_sum;
    sat_d   = 1'b0;
    if (sat_q && !red_first) begin
      acc_d = acc_q;
      sat_d = 1'b1;
    end else if ((acc_base[31] == red_sum[31]) && (acc_sum[31] != acc_base[31])) begin
      acc_d = acc_base[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      sat_q <= 1'b0;
    else if (red_vld) sat_q <= sat_d;
  end
`else
  always_comb acc_d = acc_base + red_sum;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q          <= '0;
      acc_last_q     <= 1'b0;
      result_we_q    <= 1'b0;
      result_wdata_q <= '0;
    end else begin
      if (red_vld) acc_q <= acc_d;
      acc_last_q  <= red_vld && red_last;
      result_we_q <= acc_last_q;
      if (acc_last_q) result_wdata_q <= acc_q;
    end
  end

  assign op_done      = op_done_q;
  assign op_error     = op_error_q;
  assign result_we    = result_we_q;
  assign result_wdata = result_wdata_q;

endmodule

// File: tb/tb_pipearch_dot_batch.sv
// Scoreboard bench for pipearch_dot_batch at default parameters (16 lanes, 64-deep FIFOs).
module tb_pipearch_dot_batch;

  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          op_start = 1'b0;
  logic          op_done, op_error;
  logic [31:0]   regs0 = '0, regs1 = '0;
  logic          left_rvalid = 1'b0, right_rvalid = 1'b0;
  logic [LW-1:0] left_rdata = '0, right_rdata = '0;
  logic          left_almostfull, right_almostfull;
  logic          result_we;
  logic [31:0]   result_wdata;
  logic          result_almostfull = 1'b0;

  int          tests_run = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic        last_err = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  pipearch_dot_batch dut (
    .clk              (clk),
    .resetn           (resetn),
    .op_start         (op_start),
    .op_done          (op_done),
    .op_error         (op_error),
    .regs0            (regs0),
    .regs1            (regs1),
    .left_rvalid      (left_rvalid),
    .left_rdata       (left_rdata),
    .left_almostfull  (left_almostfull),
    .right_rvalid     (right_rvalid),
    .right_rdata      (right_rdata),
    .right_almostfull (right_almostfull),
    .result_we        (result_we),
    .result_wdata     (result_wdata),
    .result_almostfull(result_almostfull)
  );

  // Records DUT output events; comparisons happen in the scenario tasks.
  always @(posedge clk) begin
    #1;
    if (result_we) obs_q.push_back(result_wdata);
    if (op_done) begin
      done_cnt++;
      last_err = op_error;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", fails);
    $fatal(1);
  end

  function automatic logic [LW-1:0] mk_line(input logic [31:0] v);
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = v;
    return l;
  endfunction

  task automatic push(input bit dl, input logic [31:0] lv, input bit dr, input logic [31:0] rv);
    @(negedge clk);
    left_rvalid  = dl;
    left_rdata   = mk_line(lv);
    right_rvalid = dr;
    right_rdata  = mk_line(rv);
    @(negedge clk);
    left_rvalid  = 1'b0;
    right_rvalid = 1'b0;
  endtask

  task automatic start_op(input int lines, input int batch, input bit bc);
    @(negedge clk);
    regs0    = {lines[15:0], batch[15:0]};
    regs1    = {31'd0, bc};
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({op_done, op_error, result_we, left_almostfull, right_almostfull, result_wdata} !== '0) begin
      fails++;
      $display("FAIL rst_in: outputs %b_%h, required all zero",
               {op_done, op_error, result_we, left_almostfull, right_almostfull}, result_wdata);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({op_done, op_error, result_we, left_almostfull, right_almostfull, result_wdata} !== '0) begin
      fails++;
      $display("FAIL rst_out: outputs %b_%h, required all zero",
               {op_done, op_error, result_we, left_almostfull, right_almostfull}, result_wdata);
    end
  endtask

  task automatic test_nonbcast();
    int d0;
    for (int i = 0; i < 6; i++) push(1'b1, 32'd1, 1'b1, 32'd2);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'd64);
    d0 = done_cnt;
    start_op(2, 3, 1'b0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    tests_run++;
    if (done_cnt != d0 + 1) begin
      fails++;
      $display("FAIL nb_done: op_done count %0d, required %0d", done_cnt - d0, 1);
    end
    tests_run++;
    if (last_err !== 1'b0) begin
      fails++;
      $display("FAIL nb_err: op_error %b, required 0", last_err);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL nb_count: %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL nb_result: got %h, required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_broadcast();
    int d0;
    for (int k = 0; k < 4; k++) push(1'b1, k, 1'b1, 32'd1);
    for (int i = 0; i < 16; i++) push(1'b0, 32'd0, 1'b1, 32'd1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'd96);
    d0 = done_cnt;
    start_op(4, 5, 1'b1);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    tests_run++;
    if (done_cnt != d0 + 1 || last_err !== 1'b0) begin
      fails++;
      $display("FAIL bc_done: op_done count %0d err %b, required 1 err 0", done_cnt - d0, last_err);
    end
    // A fresh pair afterwards must meet a drained left FIFO, not a leftover model line.
    push(1'b1, 32'd3, 1'b1, 32'd1);
    exp_q.push_back(32'd48);
    d0 = done_cnt;
    start_op(1, 1, 1'b0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL bc_count: %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL bc_result: got %h, required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    int d0;
    exp_q.push_back(32'd480);
    exp_q.push_back(32'd1248);
    for (int n = 1; n <= 3; n++) push(1'b1, n, 1'b1, 32'd3);
    d0 = done_cnt;
    start_op(4, 2, 1'b0);
    repeat (15) @(negedge clk);
    result_almostfull = 1'b1;
    for (int n = 4; n <= 8; n++) push(1'b1, n, 1'b1, 32'd3);
    repeat (10) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL bp_stall: %0d results while backpressured, required 0", obs_q.size());
    end
    result_almostfull = 1'b0;
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    tests_run++;
    if (done_cnt != d0 + 1) begin
      fails++;
      $display("FAIL bp_done: op_done count %0d, required 1", done_cnt - d0);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL bp_count: %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL bp_result: got %h, required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_bcast_overflow();
    int d0;
    push(1'b1, 32'd2, 1'b1, 32'd5);
    @(negedge clk);
    regs0    = {16'd600, 16'd1};
    regs1    = 32'd1;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    tests_run++;
    if (op_done !== 1'b0) begin
      fails++;
      $display("FAIL ovf_early: op_done %b one cycle after start, required 0", op_done);
    end
    @(negedge clk);
    tests_run++;
    if ({op_done, op_error} !== 2'b11) begin
      fails++;
      $display("FAIL ovf_done: op_done/op_error %b%b two cycles after start, required 11",
               op_done, op_error);
    end
    @(negedge clk);
    tests_run++;
    if ({op_done, op_error} !== 2'b00) begin
      fails++;
      $display("FAIL ovf_pulse: op_done/op_error %b%b, required 00", op_done, op_error);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL ovf_noresult: %0d results, required 0", obs_q.size());
    end
    // The pre-loaded pair must still be waiting in the FIFOs.
    exp_q.push_back(32'd160);
    d0 = done_cnt;
    start_op(1, 1, 1'b0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL ovf_fifo: got %h, required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_wrap();
    int d0;
    for (int i = 0; i < 2; i++) push(1'b1, 32'h4000_0000, 1'b1, 32'd2);
    for (int i = 0; i < 2; i++) push(1'b1, 32'h0400_0000, 1'b1, 32'd1);
    push(1'b1, 32'hFFFF_FFFD, 1'b1, 32'd5);
    exp_q.push_back(32'h0000_0000);
`ifdef PIPEARCH_DOT_SATURATE_EN
    exp_q.push_back(32'h7FFF_FFFF);
`else
    exp_q.push_back(32'h8000_0000);
`endif
    exp_q.push_back(32'hFFFF_FF10);
    d0 = done_cnt;
    start_op(2, 1, 1'b0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    d0 = done_cnt;
    start_op(2, 1, 1'b0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    d0 = done_cnt;
    start_op(1, 1, 1'b0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_count: %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL wrap_result: got %h, required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int d0;
    for (int i = 0; i < 3; i++) push(1'b1, 32'd1, 1'b1, 32'd1);
    start_op(4, 1, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 55; i++) push(1'b1, 32'd7, 1'b0, 32'd0);
    tests_run++;
    if (left_almostfull !== 1'b0) begin
      fails++;
      $display("FAIL af_left_55: left_almostfull %b at 55 entries, required 0", left_almostfull);
    end
    push(1'b1, 32'd7, 1'b0, 32'd0);
    tests_run++;
    if (left_almostfull !== 1'b1) begin
      fails++;
      $display("FAIL af_left_56: left_almostfull %b at 56 entries, required 1", left_almostfull);
    end
    d0 = done_cnt;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({op_done, result_we, left_almostfull, right_almostfull, result_wdata} !== '0) begin
      fails++;
      $display("FAIL mid_rst_out: outputs %b_%h, required all zero",
               {op_done, result_we, left_almostfull, right_almostfull}, result_wdata);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    tests_run++;
    if (done_cnt != d0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL mid_rst_quiet: %0d op_done and %0d results after reset, required 0 and 0",
               done_cnt - d0, obs_q.size());
    end
    obs_q.delete();
    push(1'b1, 32'd5, 1'b1, 32'd1);
    exp_q.push_back(32'd80);
    d0 = done_cnt;
    start_op(1, 1, 1'b0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL mid_rst_result: got %h, required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_almostfull_right();
    for (int i = 0; i < 55; i++) push(1'b0, 32'd0, 1'b1, 32'd1);
    tests_run++;
    if (right_almostfull !== 1'b0) begin
      fails++;
      $display("FAIL af_right_55: right_almostfull %b at 55 entries, required 0", right_almostfull);
    end
    push(1'b0, 32'd0, 1'b1, 32'd1);
    tests_run++;
    if ({right_almostfull, left_almostfull} !== 2'b10) begin
      fails++;
      $display("FAIL af_right_56: right/left almostfull %b%b at 56 right entries, required 10",
               right_almostfull, left_almostfull);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nonbcast();
    test_broadcast();
    test_backpressure();
    test_bcast_overflow();
    test_wrap();
    test_reset_mid_run();
    test_almostfull_right();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
